// File: rtl/key_loader.sv
// key_loader: assembles NUM_WORDS words into a KEY_W-bit key.
// A shadow buffer collects words while the oKey holding register presents
// the previous key, so loading and consuming keys can overlap.
module key_loader #(
   parameter  int WORD_W    = 32,
   parameter  int NUM_WORDS = 16,
   parameter  int MSB_FIRST = 0,
   localparam int KEY_W     = WORD_W * NUM_WORDS,
   localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iClear,
   input  logic [WORD_W-1:0] iWord,
   input  logic              iWord_valid,
   output logic              oWord_ready,
   output logic [KEY_W-1:0]  oKey,
   output logic              oKey_valid,
   input  logic              iKey_ack,
   output logic [CNT_W-1:0]  oWord_count,
   output logic              oPending
);

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WORDS);

   logic [0:0]       state_q, state_d;
   logic [KEY_W-1:0] shadow_q, shadow_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [CNT_W-1:0] slot;
   logic [KEY_W-1:0] merged;
   logic             accept;
   logic             ack_live;

   // Shadow contents with the incoming word dropped into its slot
   always_comb begin
      slot   = (MSB_FIRST != 0) ? (LAST_CNT - cnt_q) : cnt_q;
      merged = shadow_q;
      for (int s = 0; s < NUM_WORDS; s++) begin
         if (CNT_W'(s) == slot) merged[s*WORD_W +: WORD_W] = iWord;
      end
   end

   // Next-state logic: accept words, hand keys over, honour clear
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      cnt_d       = cnt_q;
      accept      = iWord_valid && (state_q == FILL);
      ack_live    = iKey_ack && key_valid_q;

      if (iClear) begin
         state_d     = FILL;
         shadow_d    = '0;
         key_d       = '0;
         key_valid_d = 1'b0;
         cnt_d       = '0;
      end else if (state_q == PEND) begin
         // Holding register is always valid here; an ack frees it for the shadow
         if (iKey_ack) begin
            key_d   = shadow_q;
            cnt_d   = '0;
            state_d = FILL;
         end
      end else if (accept && (cnt_q == LAST_CNT)) begin
         shadow_d = merged;
         if (!key_valid_q || iKey_ack) begin
            key_d       = merged;
            key_valid_d = 1'b1;
            cnt_d       = '0;
         end else begin
            cnt_d   = FULL_CNT;
            state_d = PEND;
         end
      end else begin
         if (accept) begin
            shadow_d = merged;
            cnt_d    = cnt_q + CNT_W'(1);
         end
         if (ack_live) key_valid_d = 1'b0;
      end
   end

   // State registers, cleared asynchronously by reset
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q     <= FILL;
         shadow_q    <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign oWord_ready = (state_q == FILL);
   assign oPending    = (state_q == PEND);
   assign oKey        = key_q;
   assign oKey_valid  = key_valid_q;
   assign oWord_count = cnt_q;

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: a word-queue model checked every cycle on the
// default instance, plus literal expectations and an MSB_FIRST instance.
module tb_key_loader;

   localparam int WORD_W = 32;
   localparam int NW     = 16;
   localparam int KEY_W  = WORD_W * NW;
   localparam int CNT_W  = $clog2(NW + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic [WORD_W-1:0] word = '0;
   logic              wvalid = 1'b0;
   logic              ack = 1'b0;
   logic              ready;
   logic [KEY_W-1:0]  key;
   logic              key_v;
   logic [CNT_W-1:0]  cnt;
   logic              pend;

   // MSB_FIRST instance, 4 x 8-bit words
   logic [7:0]  m_word = '0;
   logic        m_valid = 1'b0;
   logic        m_ready;
   logic [31:0] m_key;
   logic        m_key_v;
   logic [2:0]  m_cnt;
   logic        m_pend;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_loader #(.WORD_W(WORD_W), .NUM_WORDS(NW), .MSB_FIRST(0)) dut (
      .iClk(clk), .iRst(rst_n), .iClear(clr), .iWord(word), .iWord_valid(wvalid),
      .oWord_ready(ready), .oKey(key), .oKey_valid(key_v), .iKey_ack(ack),
      .oWord_count(cnt), .oPending(pend));

   key_loader #(.WORD_W(8), .NUM_WORDS(4), .MSB_FIRST(1)) dut_msb (
      .iClk(clk), .iRst(rst_n), .iClear(1'b0), .iWord(m_word), .iWord_valid(m_valid),
      .oWord_ready(m_ready), .oKey(m_key), .oKey_valid(m_key_v), .iKey_ack(1'b0),
      .oWord_count(m_cnt), .oPending(m_pend));

   task automatic chk(input string nm, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a queue of accepted words, the presented key, and a waiting key
   logic [WORD_W-1:0] m_part[$];
   logic [KEY_W-1:0]  mdl_hold, mdl_wait_key, built;
   bit                mdl_hold_v, mdl_waiting, acc, ackd;

   function automatic logic [KEY_W-1:0] pack_part();
      logic [KEY_W-1:0] k = '0;
      foreach (m_part[i]) k[i*WORD_W +: WORD_W] = m_part[i];
      return k;
   endfunction

   task automatic model_reset();
      m_part.delete();
      mdl_hold = '0;
      mdl_wait_key = '0;
      mdl_hold_v = 0;
      mdl_waiting = 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n || clr) model_reset();
         else if (mdl_waiting) begin
            if (ack) begin
               mdl_hold = mdl_wait_key;
               mdl_waiting = 0;
            end
         end else begin
            acc  = wvalid;
            ackd = ack && mdl_hold_v;
            if (acc) m_part.push_back(word);
            if (acc && m_part.size() == NW) begin
               built = pack_part();
               m_part.delete();
               if (!mdl_hold_v || ack) begin
                  mdl_hold = built;
                  mdl_hold_v = 1;
               end else begin
                  mdl_wait_key = built;
                  mdl_waiting = 1;
               end
            end else if (ackd) mdl_hold_v = 0;
         end
      end
   end

   // Per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      chk("oKey", key, mdl_hold);
      chk("oKey_valid", KEY_W'(key_v), KEY_W'(mdl_hold_v));
      chk("oWord_ready", KEY_W'(ready), KEY_W'(!mdl_waiting));
      chk("oPending", KEY_W'(pend), KEY_W'(mdl_waiting));
      chk("oWord_count", KEY_W'(cnt), KEY_W'(mdl_waiting ? NW : m_part.size()));
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WORD_W-1:0] w);
      word = w;
      wvalid = 1'b1;
      cycle();
   endtask

   task automatic idle();
      wvalid = 1'b0;
      cycle();
   endtask

   task automatic ack_pulse();
      wvalid = 1'b0;
      ack = 1'b1;
      cycle();
      ack = 1'b0;
   endtask

   logic [7:0] msb_words [4];

   initial begin
      msb_words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      #1;
      chk("reset_key", key, '0);
      chk("reset_cnt", KEY_W'(cnt), '0);
      chk("reset_pend", KEY_W'(pend), '0);
      cycle();
      rst_n = 1'b1;
      cycle();

      // MSB_FIRST: first word lands in the top byte
      for (int i = 0; i < 4; i++) begin
         m_word = msb_words[i];
         m_valid = 1'b1;
         cycle();
      end
      m_valid = 1'b0;
      chk("msb_key", KEY_W'(m_key), KEY_W'(32'hA1B2C3D4));
      chk("msb_valid", KEY_W'(m_key_v), KEY_W'(1));

      // Contiguous 16-word key
      for (int i = 0; i < 16; i++) send(WORD_W'(i));
      wvalid = 1'b0;
      chk("k1_valid", KEY_W'(key_v), KEY_W'(1));
      chk("k1_lo", KEY_W'(key[31:0]), KEY_W'(0));
      chk("k1_hi", KEY_W'(key[511:480]), KEY_W'(32'hF));
      ack_pulse();

      // No ack for 32 words: second key waits in the shadow
      for (int i = 0; i < 32; i++) send(WORD_W'(i));
      wvalid = 1'b0;
      chk("pend_flag", KEY_W'(pend), KEY_W'(1));
      chk("pend_ready", KEY_W'(ready), KEY_W'(0));
      chk("pend_key_lo", KEY_W'(key[31:0]), KEY_W'(0));
      ack_pulse();
      chk("k2_lo", KEY_W'(key[31:0]), KEY_W'(16));
      chk("k2_hi", KEY_W'(key[511:480]), KEY_W'(31));
      chk("k2_valid", KEY_W'(key_v), KEY_W'(1));
      chk("k2_cnt", KEY_W'(cnt), KEY_W'(0));
      ack_pulse();
      chk("k2_acked", KEY_W'(key_v), KEY_W'(0));

      // Back-to-back keys with ack held high
      ack = 1'b1;
      for (int i = 0; i < 32; i++) send(WORD_W'(32'h1000 + i));
      ack = 1'b0;
      wvalid = 1'b0;
      chk("b2b_lo", KEY_W'(key[31:0]), KEY_W'(32'h1010));
      chk("b2b_valid", KEY_W'(key_v), KEY_W'(1));
      ack_pulse();

      // Valid on alternate cycles
      for (int i = 0; i < 16; i++) begin
         send(WORD_W'(32'h100 + i));
         idle();
      end
      chk("gap_lo", KEY_W'(key[31:0]), KEY_W'(32'h100));
      chk("gap_hi", KEY_W'(key[511:480]), KEY_W'(32'h10F));

      // Clear after word 7 alongside a valid word
      for (int i = 0; i < 8; i++) send(WORD_W'(32'h55 + i));
      clr = 1'b1;
      send(WORD_W'(32'hDEAD));
      clr = 1'b0;
      wvalid = 1'b0;
      chk("clr_cnt", KEY_W'(cnt), '0);
      chk("clr_key", key, '0);
      chk("clr_valid", KEY_W'(key_v), '0);
      for (int i = 0; i < 16; i++) send(WORD_W'(32'h200 + i));
      wvalid = 1'b0;
      chk("post_clr_lo", KEY_W'(key[31:0]), KEY_W'(32'h200));
      chk("post_clr_hi", KEY_W'(key[511:480]), KEY_W'(32'h20F));

      // Reset mid-key, asserted between clock edges
      for (int i = 0; i < 5; i++) send(WORD_W'(32'h77 + i));
      wvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_key", key, '0);
      chk("arst_valid", KEY_W'(key_v), '0);
      chk("arst_cnt", KEY_W'(cnt), '0);
      cycle();
      rst_n = 1'b1;
      ack_pulse();
      chk("ack_idle_valid", KEY_W'(key_v), '0);
      chk("ack_idle_cnt", KEY_W'(cnt), '0);
      for (int i = 0; i < 16; i++) send(WORD_W'(32'h300 + i));
      wvalid = 1'b0;
      chk("post_rst_lo", KEY_W'(key[31:0]), KEY_W'(32'h300));
      chk("post_rst_valid", KEY_W'(key_v), KEY_W'(1));
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter WORD_W, default 32, width of one key word.
REQ-002 Parameter NUM_WORDS, default 16, words per key; legal range 2..256.
REQ-003 Parameter MSB_FIRST, default 0; 0 = first word lands in the LSB slot, 1 = first word lands in the MSB slot.
REQ-004 Localparam KEY_W = WORD_W*NUM_WORDS; CNT_W = $clog2(NUM_WORDS+1).
REQ-005 iClk  input  1  single clock; all state changes on the rising edge.
REQ-006 iRst  input  1  reset, asynchronous, active-low.
REQ-007 iClear  input  1  synchronous clear/zeroize, active-high.
REQ-008 iWord  input  WORD_W  key word.
REQ-009 iWord_valid  input  1  iWord is valid this cycle.
REQ-010 oWord_ready  output  1  block accepts iWord this cycle.
REQ-011 oKey  output  KEY_W  assembled key, holding register.
REQ-012 oKey_valid  output  1  oKey holds a complete, unconsumed key.
REQ-013 iKey_ack  input  1  consumer takes oKey this cycle; ignored when oKey_valid=0.
REQ-014 oWord_count  output  CNT_W  words currently held in the shadow buffer.
REQ-015 oPending  output  1  shadow full and waiting for the holding register.

Function
REQ-016 Internal KEY_W shadow buffer plus oKey holding register, which together give double buffering.
REQ-017 FSM states FILL and PEND; oWord_ready=1 only in FILL; oPending=1 only in PEND.
REQ-018 Accept = iWord_valid & oWord_ready; no word is written without accept.
REQ-019 Slot placement: with MSB_FIRST=0, iWord goes to bits [k*WORD_W +: WORD_W], where k=oWord_count; with MSB_FIRST=1, iWord goes to slot NUM_WORDS-1-k.
REQ-020 Accept with oWord_count < NUM_WORDS-1: write the slot and increment oWord_count by 1; state stays FILL.
REQ-021 Accept of the last word (oWord_count = NUM_WORDS-1) when oKey_valid=0 or iKey_ack=1:
  - next cycle oKey = shadow with the last slot replaced by iWord
  - oKey_valid=1, oWord_count=0, state stays FILL
REQ-022 Accept of the last word when oKey_valid=1 and iKey_ack=0:
  - last word written into the shadow
  - oWord_count=NUM_WORDS, state goes to PEND
REQ-023 PEND with iKey_ack=1: next cycle oKey = shadow, oKey_valid stays 1, oWord_count=0, state goes to FILL.
REQ-024 PEND with iKey_ack=0: hold all state.
REQ-025 iKey_ack with oKey_valid=1 and no transfer that cycle: oKey_valid goes to 0 next cycle; oKey value is retained.
REQ-026 Latency: oKey_valid (or a new oKey value) appears exactly 1 cycle after the final word is accepted, or 1 cycle after the ack in PEND.
REQ-027 Throughput: one word per cycle sustained; back-to-back keys need no idle cycle while the consumer acks in time.
REQ-028 iClear has priority over accept and ack. Next cycle:
  - shadow=0, oKey=0, oKey_valid=0
  - oWord_count=0, state=FILL
  - any word offered in the same cycle is dropped
REQ-029 Shadow slots not yet rewritten keep stale data; this is acceptable because every slot is rewritten before a transfer.
REQ-030 oWord_count never exceeds NUM_WORDS; no wrap-around is possible.

Reset
REQ-031 On iRst=0, immediately and asynchronously:
  - shadow=0, oKey=0, oKey_valid=0
  - oWord_count=0, state=FILL, oPending=0
REQ-032 oWord_ready=1 from the first edge after iRst deasserts.
REQ-033 Reset asserted mid-key discards the partial key; the next accepted word is slot 0.

Verification
REQ-034 Defaults: stream words 0x00000000..0x0000000F with valid held high -> oKey_valid rises 1 cycle after word 15; oKey[31:0]=0x0, oKey[511:480]=0xF.
REQ-035 MSB_FIRST=1, NUM_WORDS=4, WORD_W=8: words A1,B2,C3,D4 -> oKey=0xA1B2C3D4.
REQ-036 Defaults, no ack, stream 32 words -> first key is presented, oPending=1 after word 31 and oWord_ready=0; pulse iKey_ack -> next cycle oKey = second key, oKey_valid=1, oWord_ready=1, oWord_count=0.
REQ-037 Gaps in iWord_valid (valid on alternate cycles) -> same oKey as a contiguous stream; oWord_count increments only on accept.
REQ-038 iClear asserted after word 7, together with a valid word -> next cycle oWord_count=0, oKey=0, oKey_valid=0; the next 16 words form a clean key.
REQ-039 iRst pulsed low mid-key, including mid-cycle -> outputs are 0 immediately; iKey_ack with oKey_valid=0 produces no change.
